// File: rtl/timer_av_master.sv
// Avalon-MM master that drives the interval-timer s1 slave for a local
// command port: period/control writes, snapshot read-back and timeout clear.
// Optional: define TIMER_AV_MASTER_IRQ_EN to service av_irq (CLR state, tick,
// tick_count) and to set the ito bit in the control words.
module timer_av_master #(
  parameter int READ_LATENCY = 1,
  parameter int TICK_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [31:0]       cmd_period,
  input  logic              cmd_continuous,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [2:0]        av_address,
  output logic              av_chipselect,
  output logic              av_write_n,
  output logic [15:0]       av_writedata,
  input  logic [15:0]       av_readdata,
  input  logic              av_irq
);

  localparam int CNT_W = $clog2(READ_LATENCY + 1);

`ifdef TIMER_AV_MASTER_IRQ_EN
  localparam logic ITO = 1'b1;
`else
  localparam logic ITO = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTL, WR_STOP, WR_SNAP,
    RD_L, WAIT_L, RD_H, WAIT_H, RSP
`ifdef TIMER_AV_MASTER_IRQ_EN
    , CLR
`endif
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [31:0]      period_q;
  logic             cont_q;
  logic [CNT_W-1:0] lat_cnt;
  logic [15:0]      lo_q;
  logic             lat_done;
  logic             irq_take;
  logic             accept;

  // The wait states end once the slave's read latency has elapsed since the address cycle
  assign lat_done = (lat_cnt == CNT_W'(READ_LATENCY));

`ifdef TIMER_AV_MASTER_IRQ_EN
  assign irq_take = av_irq;
`else
  logic unused_irq;
  assign unused_irq = av_irq;
  assign irq_take   = 1'b0;
`endif

  // A pending timeout in IDLE wins over any command, so the port is not ready then
  assign cmd_ready = (state == IDLE) && !irq_take;
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = (state == RSP);

  // State register; reset aborts any sequence in progress
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // Next-state sequencing of the bus transactions
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
`ifdef TIMER_AV_MASTER_IRQ_EN
        if (irq_take) state_d = CLR;
        else
`endif
        if (accept) begin
          case (cmd_op)
            2'b00:   state_d = WR_PL;
            2'b01:   state_d = WR_STOP;
            2'b10:   state_d = WR_SNAP;
            default: state_d = IDLE;
          endcase
        end
      end
      WR_PL:   state_d = WR_PH;
      WR_PH:   state_d = WR_CTL;
      WR_CTL:  state_d = IDLE;
      WR_STOP: state_d = IDLE;
      WR_SNAP: state_d = RD_L;
      RD_L:    state_d = WAIT_L;
      WAIT_L:  if (lat_done) state_d = RD_H;
      RD_H:    state_d = WAIT_H;
      WAIT_H:  if (lat_done) state_d = RSP;
      RSP:     state_d = IDLE;
`ifdef TIMER_AV_MASTER_IRQ_EN
      CLR:     state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes are a pure decode of the state so every access is one clean cycle
  always_comb begin
    av_chipselect = 1'b0;
    av_write_n    = 1'b1;
    av_address    = 3'd0;
    av_writedata  = 16'h0000;
    case (state)
      WR_PL: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = 3'd2;
        av_writedata  = period_q[15:0];
      end
      WR_PH: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = 3'd3;
        av_writedata  = period_q[31:16];
      end
      WR_CTL: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = 3'd1;
        av_writedata  = {12'h000, 1'b0, 1'b1, cont_q, ITO};
      end
      WR_STOP: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = 3'd1;
        av_writedata  = {12'h000, 1'b1, 1'b0, cont_q, ITO};
      end
      WR_SNAP: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = 3'd4;
      end
      RD_L: begin
        av_chipselect = 1'b1;
        av_address    = 3'd4;
      end
      RD_H: begin
        av_chipselect = 1'b1;
        av_address    = 3'd5;
      end
`ifdef TIMER_AV_MASTER_IRQ_EN
      CLR: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = 3'd0;
      end
`endif
      default: ;
    endcase
  end

  // Period and mode are captured only by an accepted start; stop reuses the mode bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= 32'h0;
      cont_q   <= 1'b0;
    end else if (accept && (cmd_op == 2'b00)) begin
      period_q <= cmd_period;
      cont_q   <= cmd_continuous;
    end
  end

  // Snapshot read path: latency counter, low-half holding register and held result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt  <= '0;
      lo_q     <= 16'h0;
      rsp_data <= 32'h0;
    end else begin
      case (state)
        RD_L, RD_H: lat_cnt <= CNT_W'(1);
        WAIT_L: begin
          lat_cnt <= lat_cnt + CNT_W'(1);
          if (lat_done) lo_q <= av_readdata;
        end
        WAIT_H: begin
          lat_cnt <= lat_cnt + CNT_W'(1);
          if (lat_done) rsp_data <= {av_readdata, lo_q};
        end
        default: ;
      endcase
    end
  end

`ifdef TIMER_AV_MASTER_IRQ_EN
  // Each clear write is reported one cycle later and counted with natural wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick       <= 1'b0;
      tick_count <= '0;
    end else begin
      tick <= (state == CLR);
      if (state == CLR) tick_count <= tick_count + TICK_W'(1);
    end
  end
`else
  assign tick       = 1'b0;
  assign tick_count = '0;
`endif

endmodule

// File: tb/tb_timer_av_master.sv
// Scoreboard bench for timer_av_master: expected bus accesses, responses and
// ticks are queued when a command is issued and popped by a monitor.
// Covers both builds of TIMER_AV_MASTER_IRQ_EN and read latencies 1 and 3.
module tb_timer_av_master;

  localparam int TW = 8;
  localparam logic [15:0] LO3 = 16'hBEEF;
  localparam logic [15:0] HI3 = 16'h0003;

`ifdef TIMER_AV_MASTER_IRQ_EN
  localparam logic [15:0] START_C1 = 16'h0007;
  localparam logic [15:0] START_C0 = 16'h0005;
  localparam logic [15:0] STOP_C1  = 16'h000B;
  localparam logic [15:0] STOP_C0  = 16'h0009;
`else
  localparam logic [15:0] START_C1 = 16'h0006;
  localparam logic [15:0] START_C0 = 16'h0004;
  localparam logic [15:0] STOP_C1  = 16'h000A;
  localparam logic [15:0] STOP_C0  = 16'h0008;
`endif

  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_t;

  logic clk = 1'b0;
  logic reset_n;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [31:0]   cmd_period;
  logic          cmd_continuous;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          tick;
  logic [TW-1:0] tick_count;
  logic [2:0]    av_address;
  logic          av_chipselect;
  logic          av_write_n;
  logic [15:0]   av_writedata;
  logic [15:0]   av_readdata;
  logic          av_irq;

  logic          cmd3_valid;
  logic          cmd3_ready;
  logic [1:0]    cmd3_op;
  logic [31:0]   cmd3_period;
  logic          cmd3_cont;
  logic          rsp3_valid;
  logic [31:0]   rsp3_data;
  logic          unused_tick3;
  logic [15:0]   unused_tick_count3;
  logic [2:0]    av3_address;
  logic          av3_chipselect;
  logic          av3_write_n;
  logic [15:0]   av3_writedata;
  logic [15:0]   av3_readdata;

  logic [15:0]   snap_lo;
  logic [15:0]   snap_hi;
  logic [15:0]   rd1 = 16'h0;
  logic [15:0]   p3_0 = 16'h0;
  logic [15:0]   p3_1 = 16'h0;
  logic [15:0]   p3_2 = 16'h0;
  logic          irq_line;
  logic          irq_raise;
  logic          dut3_done;

  bus_t          bus_q[$];
  bus_t          bus3_q[$];
  logic [31:0]   rsp_q[$];
  logic [31:0]   rsp3_q[$];
  logic [TW-1:0] tick_q[$];

  int checks;
  int passes;

  always #5 clk = ~clk;

  timer_av_master #(.READ_LATENCY(1), .TICK_W(TW)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tick(tick), .tick_count(tick_count),
    .av_address(av_address), .av_chipselect(av_chipselect),
    .av_write_n(av_write_n), .av_writedata(av_writedata),
    .av_readdata(av_readdata), .av_irq(av_irq)
  );

  timer_av_master #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd3_valid), .cmd_ready(cmd3_ready), .cmd_op(cmd3_op),
    .cmd_period(cmd3_period), .cmd_continuous(cmd3_cont),
    .rsp_valid(rsp3_valid), .rsp_data(rsp3_data),
    .tick(unused_tick3), .tick_count(unused_tick_count3),
    .av_address(av3_address), .av_chipselect(av3_chipselect),
    .av_write_n(av3_write_n), .av_writedata(av3_writedata),
    .av_readdata(av3_readdata), .av_irq(1'b0)
  );

  // Latency-1 timer slave: returns the snapshot halves one cycle after the read address
  always @(posedge clk) begin
    if (av_chipselect && av_write_n)
      rd1 <= (av_address == 3'd4) ? snap_lo : (av_address == 3'd5) ? snap_hi : 16'hEEEE;
    else
      rd1 <= 16'h0000;
  end
  assign av_readdata = rd1;

  // Latency-3 timer slave for the second instance
  always @(posedge clk) begin
    if (av3_chipselect && av3_write_n)
      p3_0 <= (av3_address == 3'd4) ? LO3 : (av3_address == 3'd5) ? HI3 : 16'hEEEE;
    else
      p3_0 <= 16'h0000;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign av3_readdata = p3_2;

  // Timer interrupt line: raised on request, cleared by the slave on a status write
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      irq_line <= 1'b0;
    else if (av_chipselect && !av_write_n && (av_address == 3'd0))
      irq_line <= 1'b0;
    else if (irq_raise)
      irq_line <= 1'b1;
  end
  assign av_irq = irq_line;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic expectWrite(input logic [2:0] a, input logic [15:0] d);
    bus_q.push_back({1'b1, a, d});
  endtask

  task automatic expectRead(input logic [2:0] a);
    bus_q.push_back({1'b0, a, 16'h0000});
  endtask

  task automatic checkResetValues();
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'h0);
    checkOutput("rst_tick", 32'(tick), 32'd0);
    checkOutput("rst_tick_count", 32'(tick_count), 32'd0);
    checkOutput("rst_chipselect", 32'(av_chipselect), 32'd0);
    checkOutput("rst_write_n", 32'(av_write_n), 32'd1);
    checkOutput("rst_address", 32'(av_address), 32'd0);
    checkOutput("rst_writedata", 32'(av_writedata), 32'd0);
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] period, input logic cont);
    logic acc;
    @(negedge clk);
    cmd_valid      = 1'b1;
    cmd_op         = op;
    cmd_period     = period;
    cmd_continuous = cont;
    acc = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (cmd_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("cmd_accept", 32'(acc), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid      = 1'b0;
    cmd_op         = 2'b00;
    cmd_period     = ~period;
    cmd_continuous = ~cont;
  endtask

  task automatic waitIdle(output int busy);
    busy = 0;
    while (!cmd_ready && busy < 200) begin
      @(posedge clk);
      #1;
      busy++;
    end
  endtask

  task automatic raiseIrq();
    @(negedge clk);
    irq_raise = 1'b1;
    @(posedge clk);
    #1;
    irq_raise = 1'b0;
  endtask

  task automatic waitTick(output logic seen);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (tick) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Stimulus, monitor and the latency-3 sequence all run from one process tree
  initial begin
    int busy;
    logic seen;
    logic found;
    reset_n        = 1'b0;
    cmd_valid      = 1'b0;
    cmd_op         = 2'b11;
    cmd_period     = 32'h0;
    cmd_continuous = 1'b0;
    cmd3_valid     = 1'b0;
    cmd3_op        = 2'b10;
    cmd3_period    = 32'h0;
    cmd3_cont      = 1'b0;
    irq_raise      = 1'b0;
    snap_lo        = 16'h0;
    snap_hi        = 16'h0;
    dut3_done      = 1'b0;
    checks         = 0;
    passes         = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues();
    reset_n = 1'b1;

    fork
      forever begin
        bus_t e;
        @(negedge clk);
        if (reset_n) begin
          if (av_chipselect) begin
            if (bus_q.size() == 0) begin
              checks++;
              $display("[TB] FAIL bus_unexpected: got wr=%0b addr=%0d data=%h expected no access",
                       !av_write_n, av_address, av_writedata);
            end else begin
              e = bus_q.pop_front();
              checkOutput("bus_addr", 32'(av_address), 32'(e.addr));
              checkOutput("bus_write", 32'(!av_write_n), 32'(e.wr));
              if (e.wr) checkOutput("bus_wdata", 32'(av_writedata), 32'(e.data));
            end
          end
          if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
              checks++;
              $display("[TB] FAIL rsp_unexpected: got %h expected no response", rsp_data);
            end else checkOutput("rsp_data", rsp_data, rsp_q.pop_front());
          end
          if (tick) begin
            if (tick_q.size() == 0) begin
              checks++;
              $display("[TB] FAIL tick_unexpected: got count %h expected no tick", tick_count);
            end else checkOutput("tick_count", 32'(tick_count), 32'(tick_q.pop_front()));
          end
          if (av3_chipselect) begin
            if (bus3_q.size() == 0) begin
              checks++;
              $display("[TB] FAIL bus3_unexpected: got addr=%0d expected no access", av3_address);
            end else begin
              e = bus3_q.pop_front();
              checkOutput("bus3_addr", 32'(av3_address), 32'(e.addr));
              checkOutput("bus3_write", 32'(!av3_write_n), 32'(e.wr));
            end
          end
          if (rsp3_valid) begin
            if (rsp3_q.size() == 0) begin
              checks++;
              $display("[TB] FAIL rsp3_unexpected: got %h expected no response", rsp3_data);
            end else checkOutput("rsp3_data", rsp3_data, rsp3_q.pop_front());
          end
        end
      end
    join_none

    fork
      begin
        int b3;
        logic acc3;
        bus3_q.push_back({1'b1, 3'd4, 16'h0000});
        bus3_q.push_back({1'b0, 3'd4, 16'h0000});
        bus3_q.push_back({1'b0, 3'd5, 16'h0000});
        rsp3_q.push_back({HI3, LO3});
        @(negedge clk);
        cmd3_valid = 1'b1;
        acc3 = 1'b0;
        for (int i = 0; i < 16; i++) begin
          if (cmd3_ready) begin
            acc3 = 1'b1;
            break;
          end
          @(negedge clk);
        end
        checkOutput("rl3_accept", 32'(acc3), 32'd1);
        @(posedge clk);
        #1;
        cmd3_valid = 1'b0;
        b3 = 0;
        while (!cmd3_ready && b3 < 100) begin
          @(posedge clk);
          #1;
          b3++;
        end
        checkOutput("rl3_busy_snap", 32'(b3), 32'd10);
        dut3_done = 1'b1;
      end
    join_none

    $display("[TB] stop straight after reset uses cleared mode bit");
    expectWrite(3'd1, STOP_C0);
    applyStimulus(2'b01, 32'h0, 1'b1);
    waitIdle(busy);
    checkOutput("busy_stop", 32'(busy), 32'd1);

    $display("[TB] start continuous with period 0x000186A0");
    expectWrite(3'd2, 16'h86A0);
    expectWrite(3'd3, 16'h0001);
    expectWrite(3'd1, START_C1);
    applyStimulus(2'b00, 32'h0001_86A0, 1'b1);
    waitIdle(busy);
    checkOutput("busy_start", 32'(busy), 32'd3);

    expectWrite(3'd1, STOP_C1);
    applyStimulus(2'b01, 32'h1234_5678, 1'b0);
    waitIdle(busy);
    checkOutput("busy_stop_c1", 32'(busy), 32'd1);

    $display("[TB] one-shot start then stop");
    expectWrite(3'd2, 16'h0000);
    expectWrite(3'd3, 16'hFFFF);
    expectWrite(3'd1, START_C0);
    applyStimulus(2'b00, 32'hFFFF_0000, 1'b0);
    waitIdle(busy);
    expectWrite(3'd1, STOP_C0);
    applyStimulus(2'b01, 32'h0, 1'b1);
    waitIdle(busy);

    applyStimulus(2'b11, 32'hCAFE_F00D, 1'b1);
    waitIdle(busy);
    checkOutput("busy_noop", 32'(busy), 32'd0);

    $display("[TB] snapshots at read latency 1");
    snap_lo = 16'h1234;
    snap_hi = 16'h0005;
    expectWrite(3'd4, 16'h0000);
    expectRead(3'd4);
    expectRead(3'd5);
    rsp_q.push_back(32'h0005_1234);
    applyStimulus(2'b10, 32'h0, 1'b0);
    waitIdle(busy);
    checkOutput("busy_snap", 32'(busy), 32'd6);

    snap_lo = 16'hABCD;
    snap_hi = 16'h8000;
    expectWrite(3'd4, 16'h0000);
    expectRead(3'd4);
    expectRead(3'd5);
    rsp_q.push_back(32'h8000_ABCD);
    applyStimulus(2'b10, 32'h0, 1'b0);
    waitIdle(busy);
    repeat (3) @(negedge clk);
    checkOutput("rsp_hold", rsp_data, 32'h8000_ABCD);

    for (int k = 0; k < 100 && !dut3_done; k++) @(negedge clk);
    checkOutput("rl3_done", 32'(dut3_done), 32'd1);

`ifdef TIMER_AV_MASTER_IRQ_EN
    $display("[TB] single timeout service");
    expectWrite(3'd0, 16'h0000);
    tick_q.push_back(TW'(1));
    raiseIrq();
    waitTick(seen);
    checkOutput("irq_serviced", 32'(seen), 32'd1);
    repeat (5) @(negedge clk);
    checkOutput("tick_count_single", 32'(tick_count), 32'd1);

    $display("[TB] timeout and start together");
    expectWrite(3'd0, 16'h0000);
    tick_q.push_back(TW'(2));
    raiseIrq();
`else
    $display("[TB] interrupt ignored without servicing");
    raiseIrq();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("tick_tied0", 32'(tick), 32'd0);
    end
    checkOutput("tick_count_tied0", 32'(tick_count), 32'd0);
`endif
    expectWrite(3'd2, 16'h0010);
    expectWrite(3'd3, 16'h0000);
    expectWrite(3'd1, START_C1);
    applyStimulus(2'b00, 32'h0000_0010, 1'b1);
    waitIdle(busy);
    checkOutput("busy_start_irq", 32'(busy), 32'd3);

`ifdef TIMER_AV_MASTER_IRQ_EN
    $display("[TB] tick_count wrap");
    for (int n = 3; n <= 257; n++) begin
      expectWrite(3'd0, 16'h0000);
      tick_q.push_back(TW'(n));
      raiseIrq();
      waitTick(seen);
      checkOutput("irq_serviced", 32'(seen), 32'd1);
      if (n == 256) checkOutput("tick_count_wrap", 32'(tick_count), 32'd0);
    end
`endif

    $display("[TB] reset during second read wait");
    snap_lo = 16'h1111;
    snap_hi = 16'h2222;
    expectWrite(3'd4, 16'h0000);
    expectRead(3'd4);
    expectRead(3'd5);
    applyStimulus(2'b10, 32'h0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (av_chipselect && av_write_n && av_address == 3'd5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("reached_rd_h", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkResetValues();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    snap_lo = 16'h0F0F;
    snap_hi = 16'h7070;
    expectWrite(3'd4, 16'h0000);
    expectRead(3'd4);
    expectRead(3'd5);
    rsp_q.push_back(32'h7070_0F0F);
    applyStimulus(2'b10, 32'h0, 1'b0);
    waitIdle(busy);
    checkOutput("busy_snap_after_rst", 32'(busy), 32'd6);

    expectWrite(3'd1, STOP_C0);
    applyStimulus(2'b01, 32'h0, 1'b1);
    waitIdle(busy);
    repeat (4) @(negedge clk);
    checkOutput("rsp_hold_after_stop", rsp_data, 32'h7070_0F0F);

    checkOutput("bus_q_drained", 32'(bus_q.size()), 32'd0);
    checkOutput("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    checkOutput("tick_q_drained", 32'(tick_q.size()), 32'd0);
    checkOutput("bus3_q_drained", 32'(bus3_q.size()), 32'd0);
    checkOutput("rsp3_q_drained", 32'(rsp3_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
